// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   FETCH_ADDR_W / FETCH_INSTR_W : default PC and instruction widths
//   PC_STEP                      : byte distance between consecutive fetch words
//   fetch_entry_t                : {pc, instr} pair held in the prefetch FIFO
package fetch_pkg;
   localparam int FETCH_ADDR_W  = 32;
   localparam int FETCH_INSTR_W = 32;
   localparam int PC_STEP       = 4;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0]  pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, instr} entries.
//   clk, reset (sync, active low)
//   push/pushData : write an entry (caller guarantees space)
//   pop           : advance head (ignored when empty)
//   flush         : drop all entries; wins over push/pop
//   head/notEmpty : current head entry; when empty, head holds the last entry shown
//   count         : number of stored entries (0..DEPTH)
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t,
   parameter int  CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  entry_t           pushData,
   input  logic             pop,
   input  logic             flush,
   output entry_t           head,
   output logic             notEmpty,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   entry_t           mem [DEPTH];
   entry_t           lastHead;
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic             doPush, doPop;

   assign notEmpty = (count != '0);
   assign doPush   = push && !flush;
   assign doPop    = pop && notEmpty && !flush;
   // Empty FIFO keeps presenting whatever decode last saw.
   assign head     = notEmpty ? mem[rdPtr] : lastHead;

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rdPtr    <= '0;
         wrPtr    <= '0;
         count    <= '0;
         lastHead <= '0;
      end else begin
         if (notEmpty) lastHead <= mem[rdPtr];
         if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
         end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
         end
      end
   end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: stallable, redirectable instruction fetch front end.
//   Owns the PC, issues word reads to instruction memory and buffers returned
//   words in a DEPTH-entry prefetch FIFO presented to decode via valid/ready.
//   clk, reset (sync, active low)
//   imem_req/imem_addr/imem_gnt       : read request channel
//   imem_rvalid/imem_rdata            : in-order read responses
//   redirect_valid/redirect_pc        : branch/exception redirect
//   dec_valid/dec_pc/dec_instr/dec_ready : decode handshake
//   stall_cycles (only with FETCH_PERF_EN defined): saturating count of cycles
//     where decode was ready but nothing was available.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                INSTR_W  = FETCH_INSTR_W,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               dec_valid,
   output logic [ADDR_W-1:0]  dec_pc,
   output logic [INSTR_W-1:0] dec_instr,
   input  logic               dec_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        stall_cycles
`endif
);
   localparam int              CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]  CREDITS = (CNT_W+1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   logic [ADDR_W-1:0] pc, respPc, redirTarget;
   logic [CNT_W-1:0]  outstanding, discard, fifoCount;
   logic [CNT_W:0]    inUse;
   logic              issue, rspValid, pushEn, popEn;
   entry_t            pushData, headEntry;
   logic              unusedRedirLsb;

   assign unusedRedirLsb = ^redirect_pc[1:0];
   assign redirTarget    = {redirect_pc[ADDR_W-1:2], 2'b00};

   // Credit: every in-flight request owns a FIFO slot, so a push can never
   // meet a full FIFO. In-flight responses marked for discard still hold credit.
   assign inUse     = {1'b0, fifoCount} + {1'b0, outstanding};
   assign imem_req  = reset && !redirect_valid && (inUse < CREDITS);
   assign imem_addr = pc;   // pc only moves on grant, so addr is stable while waiting
   assign issue     = imem_req && imem_gnt;

   // A response with nothing outstanding is illegal and simply ignored.
   assign rspValid  = imem_rvalid && (outstanding != '0);
   assign pushEn    = rspValid && (discard == '0) && !redirect_valid;
   assign popEn     = dec_valid && dec_ready && !redirect_valid;
   assign pushData  = {respPc, imem_rdata};

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc          <= RESET_PC;
         respPc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rspValid);
         if (redirect_valid) begin
            pc      <= redirTarget;
            respPc  <= redirTarget;
            // discard + live in-flight - retiring; outstanding already includes
            // the earlier discards, so this is every response still to come.
            // This keeps back-to-back redirects from double counting.
            discard <= outstanding - CNT_W'(rspValid);
         end else begin
            if (issue)  pc     <= pc + ADDR_W'(PC_STEP);
            if (pushEn) respPc <= respPc + ADDR_W'(PC_STEP);
            if (rspValid && (discard != '0)) discard <= discard - CNT_W'(1);
         end
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t),
      .CNT_W   (CNT_W)
   ) uFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (pushEn),
      .pushData (pushData),
      .pop      (popEn),
      .flush    (redirect_valid),
      .head     (headEntry),
      .notEmpty (dec_valid),
      .count    (fifoCount)
   );

   assign dec_pc    = headEntry.pc;
   assign dec_instr = headEntry.instr;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset)
         stall_cycles <= '0;
      else if (dec_ready && !dec_valid && !redirect_valid && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset && imem_rvalid) begin
         rvalidWithoutRequest: assert (outstanding != '0);
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
//   Memory model returns instrOf(addr) in order after a configurable latency.
//   Reference model: queue of requests in flight (with a stale flag set on
//   redirect) and a queue of entries visible to decode.
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;
   logic        dec_ready;
`ifdef FETCH_PERF_EN
   logic [31:0] stall_cycles;
`endif

   fetch_queue #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_pc         (dec_pc),
      .dec_instr      (dec_instr),
      .dec_ready      (dec_ready)
`ifdef FETCH_PERF_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; bit stale; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   typedef struct { logic [31:0] addr; int due; } mem_t;

   pend_t       pendQ[$];
   ent_t        fifoQ[$];
   mem_t        memQ[$];
   logic [31:0] mPc;
   ent_t        lastShown;
   logic [31:0] mStall;
   int          cyc, lastDue, lat;
   bit          randLat;
   int          errs, checks;
   bit          obsReq, obsValid;
   logic [31:0] obsPc, obsInstr;

   function automatic logic [31:0] instrOf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // One clock cycle: drive at the low phase, compare against the model,
   // then advance memory and model at the rising edge.
   task automatic cycle(input bit gntIn, input bit rdyIn, input bit redirIn, input logic [31:0] redirPc);
      bit          expReq, expValid, issue, pop, memIssue, rv;
      ent_t        expHead;
      pend_t       p;
      mem_t        m;
      logic [31:0] grantAddr;
      int          l;
      rv             = (memQ.size() != 0) && (memQ[0].due <= cyc);
      imem_rvalid    = rv;
      imem_rdata     = rv ? instrOf(memQ[0].addr) : 32'h0;
      imem_gnt       = gntIn;
      dec_ready      = rdyIn;
      redirect_valid = redirIn;
      redirect_pc    = redirPc;
      #1;
      expReq   = !redirIn && ((fifoQ.size() + pendQ.size()) < DEPTH);
      expValid = (fifoQ.size() != 0);
      expHead  = expValid ? fifoQ[0] : lastShown;
      obsReq   = imem_req;
      obsValid = dec_valid;
      obsPc    = dec_pc;
      obsInstr = dec_instr;
      checks++;
      if (imem_req !== expReq) begin
         errs++; $display("FAIL imem_req cyc=%0d: got %b expected %b", cyc, imem_req, expReq);
      end
      if (expReq) begin
         checks++;
         if (imem_addr !== mPc) begin
            errs++; $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, imem_addr, mPc);
         end
      end
      checks++;
      if (dec_valid !== expValid) begin
         errs++; $display("FAIL dec_valid cyc=%0d: got %b expected %b", cyc, dec_valid, expValid);
      end
      checks++;
      if (dec_pc !== expHead.pc) begin
         errs++; $display("FAIL dec_pc cyc=%0d: got %h expected %h", cyc, dec_pc, expHead.pc);
      end
      checks++;
      if (dec_instr !== expHead.instr) begin
         errs++; $display("FAIL dec_instr cyc=%0d: got %h expected %h", cyc, dec_instr, expHead.instr);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (stall_cycles !== mStall) begin
         errs++; $display("FAIL stall_cycles cyc=%0d: got %0d expected %0d", cyc, stall_cycles, mStall);
      end
`endif
      memIssue  = (imem_req === 1'b1) && gntIn;
      grantAddr = imem_addr;
      issue     = expReq && gntIn;
      pop       = expValid && rdyIn;
      @(posedge clk);
      // memory side: follows what the DUT actually asked for
      if (rv) void'(memQ.pop_front());
      if (memIssue) begin
         l      = randLat ? int'($urandom_range(1, 4)) : lat;
         m.addr = grantAddr;
         m.due  = cyc + l;
         if (m.due <= lastDue) m.due = lastDue + 1;
         lastDue = m.due;
         memQ.push_back(m);
      end
      // reference model
      if (expValid) lastShown = fifoQ[0];
`ifdef FETCH_PERF_EN
      if (rdyIn && !expValid && !redirIn && (mStall != 32'hFFFF_FFFF)) mStall++;
`endif
      p.pc = 32'h0; p.stale = 1'b1;
      if (rv && (pendQ.size() != 0)) p = pendQ.pop_front();
      if (redirIn) begin
         foreach (pendQ[i]) pendQ[i].stale = 1'b1;
         fifoQ.delete();
         mPc = {redirPc[31:2], 2'b00};
      end else begin
         if (issue) begin
            pendQ.push_back('{pc: mPc, stale: 1'b0});
            mPc = mPc + 32'd4;
         end
         if (pop) void'(fifoQ.pop_front());
         if (rv && !p.stale) fifoQ.push_back('{pc: p.pc, instr: instrOf(p.pc)});
      end
      cyc++;
      @(negedge clk);
   endtask

   // Asserts reset across one rising edge and returns at the following low phase.
   task automatic applyReset();
      reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
      @(posedge clk);
      memQ.delete(); pendQ.delete(); fifoQ.delete();
      mPc = 32'h0; lastShown.pc = 32'h0; lastShown.instr = 32'h0; mStall = 32'h0; lastDue = 0;
      @(negedge clk);
   endtask

   task automatic releaseReset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      applyReset();
      checks++; if (imem_req !== 1'b0) begin errs++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
      checks++; if (dec_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", dec_valid); end
      checks++; if (dec_pc !== 32'h0) begin errs++; $display("FAIL reset_pc: got %h expected 0", dec_pc); end
      checks++; if (dec_instr !== 32'h0) begin errs++; $display("FAIL reset_instr: got %h expected 0", dec_instr); end
      releaseReset();
   endtask

   task automatic test_stream();
      logic [31:0] seen[$];
      applyReset(); releaseReset();
      lat = 1; randLat = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (obsValid) seen.push_back(obsPc);
      end
      checks++;
      if (seen.size() != 10) begin errs++; $display("FAIL stream_count: got %0d expected 10", seen.size()); end
      for (int i = 0; i < seen.size(); i++) begin
         checks++;
         if (seen[i] !== 32'(4 * i)) begin
            errs++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, seen[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      int nIss;
      applyReset(); releaseReset();
      lat = 1; nIss = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 32'h0);
         if (obsReq) nIss++;
      end
      checks++; if (nIss != DEPTH) begin errs++; $display("FAIL bp_issued: got %0d expected %0d", nIss, DEPTH); end
      checks++; if (obsReq !== 1'b0) begin errs++; $display("FAIL bp_req_full: got %b expected 0", obsReq); end
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (obsReq !== 1'b0) begin errs++; $display("FAIL bp_req_popcycle: got %b expected 0", obsReq); end
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (obsReq !== 1'b1) begin errs++; $display("FAIL bp_req_resume: got %b expected 1", obsReq); end
   endtask

   task automatic test_redirect_latency();
      bit found;
      applyReset(); releaseReset();
      lat = 3;
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 32'h103);
      checks++; if (obsReq !== 1'b0) begin errs++; $display("FAIL redir_req: got %b expected 0", obsReq); end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (obsValid) found = 1;
      end
      checks++; if (!found) begin errs++; $display("FAIL redir_timeout: got none expected 00000100"); end
      checks++; if (obsPc !== 32'h100) begin errs++; $display("FAIL redir_first_pc: got %h expected 00000100", obsPc); end
      checks++;
      if (obsInstr !== instrOf(32'h100)) begin
         errs++; $display("FAIL redir_first_instr: got %h expected %h", obsInstr, instrOf(32'h100));
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (obsValid) found = 1;
      end
      checks++; if (!found || obsPc !== 32'h104) begin errs++; $display("FAIL redir_second_pc: got %h expected 00000104", obsPc); end
   endtask

   task automatic test_redirect_same_cycle();
      bit found;
      applyReset(); releaseReset();
      lat = 2;
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 32'h200);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (obsValid !== 1'b0) begin errs++; $display("FAIL same_flush: got %b expected 0", obsValid); end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (obsValid) found = 1;
      end
      checks++; if (!found || obsPc !== 32'h200) begin errs++; $display("FAIL same_target_pc: got %h expected 00000200", obsPc); end
   endtask

   task automatic test_wrap();
      logic [31:0] seen[$];
      applyReset(); releaseReset();
      lat = 1;
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (obsValid) seen.push_back(obsPc);
      end
      checks++;
      if (seen.size() < 3) begin
         errs++; $display("FAIL wrap_count: got %0d expected >=3", seen.size());
      end else begin
         checks++; if (seen[0] !== 32'hFFFF_FFF8) begin errs++; $display("FAIL wrap_pc0: got %h expected fffffff8", seen[0]); end
         checks++; if (seen[1] !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_pc1: got %h expected fffffffc", seen[1]); end
         checks++; if (seen[2] !== 32'h0000_0000) begin errs++; $display("FAIL wrap_pc2: got %h expected 00000000", seen[2]); end
      end
   endtask

   task automatic test_random();
      int nValid;
      applyReset(); releaseReset();
      randLat = 1; nValid = 0;
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, $urandom());
         if (obsValid) nValid++;
      end
      randLat = 0;
      checks++; if (nValid < 20) begin errs++; $display("FAIL random_activity: got %0d expected >=20", nValid); end
   endtask

   task automatic test_reset_midstream();
      applyReset(); releaseReset();
      lat = 3;
      cycle(1'b1, 1'b1, 1'b1, 32'h40);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      applyReset();
      checks++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mid_req: got %b expected 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL mid_addr: got %h expected 0", imem_addr); end
      checks++; if (dec_valid !== 1'b0) begin errs++; $display("FAIL mid_valid: got %b expected 0", dec_valid); end
      checks++; if (dec_pc !== 32'h0) begin errs++; $display("FAIL mid_pc: got %h expected 0", dec_pc); end
      checks++; if (dec_instr !== 32'h0) begin errs++; $display("FAIL mid_instr: got %h expected 0", dec_instr); end
`ifdef FETCH_PERF_EN
      checks++; if (stall_cycles !== 32'h0) begin errs++; $display("FAIL mid_stall: got %0d expected 0", stall_cycles); end
`endif
      releaseReset();
      lat = 1;
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      applyReset(); releaseReset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
      checks++; if (stall_cycles !== 32'd5) begin errs++; $display("FAIL perf_count: got %0d expected 5", stall_cycles); end
   endtask
`endif

   initial begin
      errs = 0; checks = 0; cyc = 0; lastDue = 0; lat = 1; randLat = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_latency();
      test_redirect_same_cycle();
      test_wrap();
      test_random();
      test_reset_midstream();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
